mem_responder: RTL and testbench

// - Data-side memory responder for the core's memAction channel: accepts {memOp, memMask, memAdr, memDat}

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_req_fifo.sv | 30 +++
 rtl/mem_responder.sv | 73 +++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared request types and byte-mask helpers for mem_responder
package mem_pkg;
  typedef enum logic [1:0] {MEM_LOAD, MEM_STORE, MEM_SWAP, MEM_RSVD} mem_op_e;
  typedef struct packed {
    mem_op_e     op;
    logic [7:0]  mask;
    logic [63:0] addr;
    logic [63:0] data;
  } mem_req_t;
  function automatic logic [63:0] mask_expand(input logic [7:0] mask);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{mask[i]}};
    return m;
  endfunction
  // Legal masks are empty or a naturally aligned 1/2/4/8-byte run starting at lo.
  function automatic logic misaligned(input logic [2:0] lo, input logic [7:0] mask);
    return !(mask == 8'h00 || mask == 8'h01 << lo || (!lo[0] && mask == 8'h03 << lo) ||
             (lo[1:0] == 2'b00 && mask == 8'h0F << lo) || (lo == 3'b000 && mask == 8'hFF));
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response handshake bundle for mem_responder
interface mem_responder_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [7:0]        req_mask;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic              resp_exc;
  modport master(output req_valid, req_op, req_mask, req_addr, req_data, resp_ready,
                 input req_ready, resp_valid, resp_data, resp_exc);
  modport slave(input req_valid, req_op, req_mask, req_addr, req_data, resp_ready,
                output req_ready, resp_valid, resp_data, resp_exc);
endinterface

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous FIFO of mem_req_t with wrap-bit pointers
module mem_req_fifo import mem_pkg::*; #(parameter int QDEPTH = 4) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  mem_req_t i_data,
  input  logic     i_pop,
  output mem_req_t o_data,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(QDEPTH);
  mem_req_t r_mem [QDEPTH];
  logic [AW:0] r_wr, r_rd;
  assign o_empty = r_wr == r_rd;
  assign o_full = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
  assign o_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop && !o_empty) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: buffered data-memory responder with programmable latency.
// Define MEM_RESP_MISALIGN_CHECK_EN to fault masks not naturally aligned to req_addr[2:0].
module mem_responder import mem_pkg::*; #(
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 3
) (
  input logic CLK,
  input logic RESET,
  mem_responder_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  mem_req_t r_op, w_req, w_head;
  logic w_empty, w_full, w_pop, w_fire, w_exc, w_mis, w_unused;
  logic r_resp_valid, r_resp_exc;
  logic [63:0] r_resp_data, w_old, w_m;
  logic [63:0] r_mem [DEPTH];
  logic [IW-1:0] w_idx;
  assign w_req = '{op: mem_op_e'(bus.req_op), mask: bus.req_mask,
                   addr: 64'(bus.req_addr[ADDR_W-1:0]), data: bus.req_data};
  mem_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(CLK), .rst(RESET), .i_push(bus.req_valid && bus.req_ready), .i_data(w_req),
    .i_pop(w_pop), .o_data(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  assign bus.req_ready = !w_full && !RESET;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data = r_resp_data;
  assign bus.resp_exc = r_resp_exc;
  assign w_idx = r_op.addr[3 +: IW];
  assign w_old = r_mem[w_idx];
  assign w_m = mask_expand(r_op.mask);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
  assign w_mis = misaligned(r_op.addr[2:0], r_op.mask);
`else
  assign w_mis = 1'b0;
`endif
  assign w_unused = ^r_op.addr[2:0];
  assign w_exc = r_op.op == MEM_RSVD || r_op.addr[63:3] >= 61'(DEPTH) || w_mis;
  always_comb begin
    w_pop = r_state == IDLE && !w_empty;
    w_fire = r_state == BUSY && r_cnt == '0;
    w_next = w_pop ? BUSY : w_fire ? RESP : (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data <= '0;
      r_resp_exc <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_op <= w_head;
        r_cnt <= CW'(LATENCY - 1);
      end else if (r_state == BUSY && !w_fire) r_cnt <= r_cnt - 1'b1;
      if (w_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_data <= (w_exc || r_op.op == MEM_STORE) ? '0 : w_old & w_m;
        r_resp_exc <= w_exc;
      end else if (r_state == RESP && bus.resp_ready) r_resp_valid <= 1'b0;
    end
  end
  // Storage is deliberately not reset; SWAP reads w_old before this write lands.
  always_ff @(posedge CLK)
    if (!RESET && w_fire && !w_exc && r_op.op != MEM_LOAD)
      r_mem[w_idx] <= (w_old & ~w_m) | (r_op.data & w_m);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder with a byte-array reference model
module tb_mem_responder;
  localparam int DEPTH = 1024, QDEPTH = 4, LATENCY = 3;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_responder_if #(.ADDR_W(64)) bus();
  mem_responder #(.ADDR_W(64), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .LATENCY(LATENCY)) dut (
    .CLK(clk), .RESET(rst), .bus(bus.slave)
  );
  int errors = 0, checks = 0, ready_mode = 0;
  logic [7:0] mem_b [DEPTH*8];
  logic [64:0] exp_q [$];
  logic [63:0] last_data = '0, w0 = '0;
  logic last_exc = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef MEM_RESP_MISALIGN_CHECK_EN
  function automatic logic tb_misaligned(logic [2:0] lo, logic [7:0] mask);
    int n = $countones(mask);
    int first = 0;
    if (mask == 8'h00) return 1'b0;
    while (!mask[first]) first++;
    return !((n == 1 || n == 2 || n == 4 || n == 8) && first == int'(lo) && int'(lo) % n == 0 &&
             mask == 8'(((1 << n) - 1) << first));
  endfunction
`endif

  // Byte-granular model: applies each request's effect in acceptance order.
  function automatic void model(logic [1:0] op, logic [7:0] mask, logic [63:0] addr,
                                logic [63:0] data, output logic [63:0] rd, output logic exc);
    longint unsigned base;
    exc = op == 2'd3 || addr >= 64'(DEPTH) * 8;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    exc = exc || tb_misaligned(addr[2:0], mask);
`endif
    rd = '0;
    if (!exc) begin
      base = addr & ~64'd7;
      for (int b = 0; b < 8; b++)
        if (mask[b]) begin
          if (op != 2'd1) rd[8*b +: 8] = mem_b[base + b];
          if (op != 2'd0) mem_b[base + b] = data[8*b +: 8];
        end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    bus.resp_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk)
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h with no request outstanding", bus.resp_data);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("resp_data", bus.resp_data, e[63:0]);
        check("resp_exc", 64'(bus.resp_exc), 64'(e[64]));
        last_data = bus.resp_data;
        last_exc = bus.resp_exc;
      end
    end

  task automatic send(logic [1:0] op, logic [7:0] mask, logic [63:0] addr, logic [63:0] data);
    logic [63:0] rd;
    logic exc;
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_mask = mask;
    bus.req_addr = addr;
    bus.req_data = data;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got req_ready=0 for %0d cycles required 1", n);
    end else begin
      @(posedge clk);
      model(op, mask, addr, data, rd, exc);
      exp_q.push_back({exc, rd});
    end
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_latency(string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.resp_valid && n < 50);
    check(name, 64'(n), 64'(LATENCY + 1));
  endtask

  task automatic expect_last(string name, logic [63:0] d, logic e);
    check({name, "_data"}, last_data, d);
    check({name, "_exc"}, 64'(last_exc), 64'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_mask = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("post_reset_resp_data", bus.resp_data, 64'd0);
    check("post_reset_resp_exc", 64'(bus.resp_exc), 64'd0);
    send(2'd1, 8'hFF, 64'h10, 64'h1122334455667788);
    check_latency("latency_store");
    drain();
    expect_last("store_0x10", 64'd0, 1'b0);
    send(2'd0, 8'hFF, 64'h10, 64'd0);
    check_latency("latency_load");
    drain();
    expect_last("load_0x10", 64'h1122334455667788, 1'b0);
    send(2'd1, 8'hFF, 64'h18, '1);
    send(2'd1, 8'h0F, 64'h18, 64'd0);
    send(2'd0, 8'hFF, 64'h18, 64'd0);
    drain();
    expect_last("load_0x18", 64'hFFFFFFFF00000000, 1'b0);
    send(2'd2, 8'hFF, 64'h10, 64'hA5A5A5A5A5A5A5A5);
    drain();
    expect_last("swap_old", 64'h1122334455667788, 1'b0);
    send(2'd0, 8'hFF, 64'h10, 64'd0);
    drain();
    expect_last("load_after_swap", 64'hA5A5A5A5A5A5A5A5, 1'b0);
    send(2'd0, 8'h00, 64'h10, 64'd0);
    drain();
    expect_last("load_mask0", 64'd0, 1'b0);
    for (int w = 0; w < 16; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if (w == 0) w0 = d;
      send(2'd1, 8'hFF, 64'(w * 8), d);
    end
    send(2'd3, 8'hFF, 64'h0, 64'hDEADBEEFDEADBEEF);
    drain();
    expect_last("op_rsvd", 64'd0, 1'b1);
    send(2'd1, 8'hFF, 64'(DEPTH * 8), 64'hBEEFBEEFBEEFBEEF);
    drain();
    expect_last("addr_oob", 64'd0, 1'b1);
    send(2'd0, 8'hFF, 64'h0, 64'd0);
    drain();
    expect_last("word0_unchanged", w0, 1'b0);
    ready_mode = 2;
    for (int i = 0; i < QDEPTH + 1; i++) send(2'd0, 8'hFF, 64'(i * 8), 64'd0);
    @(negedge clk);
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    check("bp_outstanding", 64'(exp_q.size()), 64'(QDEPTH + 1));
    ready_mode = 0;
    drain();
    check("bp_drained", 64'(exp_q.size()), 64'd0);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    send(2'd0, 8'h06, 64'h11, 64'd0);
    drain();
    expect_last("misalign_0x11", 64'd0, 1'b1);
    send(2'd0, 8'h0C, 64'h12, 64'd0);
    drain();
    check("aligned_0x12_exc", 64'(last_exc), 64'd0);
`endif
    ready_mode = 1;
    repeat (300) begin
      logic [1:0] op;
      logic [63:0] addr;
      op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = addr + 64'(DEPTH * 8);
      send(op, 8'($urandom), addr, {$urandom, $urandom});
    end
    ready_mode = 0;
    drain();
    check("final_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
